// File: rtl/serial_recv.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// 1-cycle VALID / FRAME_ERR pulses and break handling.
module serial_recv #(
  parameter int WAIT_DIV = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam logic [CW-1:0] HALF_END = CW'(WAIT_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(WAIT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic          tick;
  logic          cnt_clr;
  logic          shift_en;
  logic          valid_nxt;
  logic          ferr_nxt;

  // State register plus all datapath flops
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      DATA_OUT  <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      sync1     <= DATA_IN;
      rx_s      <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == START)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;
      if (shift_en)
        shreg   <= {rx_s, shreg[7:1]};
      if (valid_nxt)
        DATA_OUT <= shreg;
      VALID     <= valid_nxt;
      FRAME_ERR <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt == HALF_END) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (cnt == BIT_END && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (cnt == BIT_END) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Leaving STOP at mid stop bit lets a back-to-back start bit be caught
  always_comb begin
    tick      = (state == START) ? (cnt == HALF_END) : (cnt == BIT_END);
    cnt_clr   = (state == IDLE) || (state == BREAK) || tick;
    shift_en  = (state == DATA) && (cnt == BIT_END);
    valid_nxt = (state == STOP) && (cnt == BIT_END) && rx_s;
    ferr_nxt  = (state == STOP) && (cnt == BIT_END) && !rx_s;
    BUSY      = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_recv.sv
// Scoreboard bench for serial_recv at WAIT_DIV=5: bench-side bit-banged
// transmitter pushes expected bytes, a negedge monitor pops them on VALID.
module tb_serial_recv;

  localparam int W = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_IN = 1'b1;
  logic [7:0] DATA_OUT;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int last_valid_cyc = 0;
  logic [7:0] exp_q[$];

  serial_recv #(.WAIT_DIV(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (VALID) begin
      n_valid++;
      last_valid_cyc = cyc;
      check("valid_ferr_excl", {31'd0, FRAME_ERR}, 32'd0);
      check("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0)
        check("sb_data", {24'd0, DATA_OUT}, {24'd0, exp_q.pop_front()});
    end
    if (FRAME_ERR) n_ferr++;
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    DATA_IN = b;
    idle_cycles(W);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit good);
    if (good) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  initial begin
    int v0, f0, busy_cnt, k0;
    logic [7:0] fb;

    // Reset state
    idle_cycles(2);
    check("rst_data", {24'd0, DATA_OUT}, 32'd0);
    check("rst_valid", {31'd0, VALID}, 32'd0);
    check("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b1;
    idle_cycles(3);

    // Single frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h41, 1'b1, 1'b1);
    idle_cycles(4);
    check("t1_valid_cnt", n_valid - v0, 1);
    check("t1_ferr_cnt", n_ferr - f0, 0);
    check("t1_busy", {31'd0, BUSY}, 32'd0);
    check("t1_data", {24'd0, DATA_OUT}, 32'h41);

    // Back-to-back frames, no idle gap
    v0 = n_valid;
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    idle_cycles(4);
    check("t2_valid_cnt", n_valid - v0, 2);
    check("t2_data", {24'd0, DATA_OUT}, 32'hAA);

    // One-clock glitch
    v0 = n_valid;
    busy_cnt = 0;
    DATA_IN = 1'b0;
    idle_cycles(1);
    DATA_IN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (BUSY) busy_cnt++;
    end
    idle_cycles(1);
    check("t3_busy_le3", {31'd0, busy_cnt <= 3}, 32'd1);
    check("t3_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
    check("t3_valid_cnt", n_valid - v0, 0);
    check("t3_busy_end", {31'd0, BUSY}, 32'd0);
    check("t3_data", {24'd0, DATA_OUT}, 32'hAA);

    // Framing error followed by a held-low line
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hC3, 1'b0, 1'b0);
    idle_cycles(20);
    check("t4_ferr_cnt", n_ferr - f0, 1);
    check("t4_valid_cnt", n_valid - v0, 0);
    check("t4_data", {24'd0, DATA_OUT}, 32'hAA);
    check("t4_busy_low", {31'd0, BUSY}, 32'd1);
    DATA_IN = 1'b1;
    idle_cycles(5);
    check("t4_busy_rel", {31'd0, BUSY}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b1);
    idle_cycles(4);
    check("t4_valid_after", n_valid - v0, 1);
    check("t4_ferr_after", n_ferr - f0, 1);
    check("t4_data_after", {24'd0, DATA_OUT}, 32'h12);

    // Reset during data bit 4 of 8'hF0
    v0 = n_valid;
    fb = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(fb[i]);
    DATA_IN = fb[4];
    idle_cycles(2);
    check("t5_busy_pre", {31'd0, BUSY}, 32'd1);
    RST = 1'b0;
    #1;
    check("t5_rst_data", {24'd0, DATA_OUT}, 32'd0);
    check("t5_rst_busy", {31'd0, BUSY}, 32'd0);
    check("t5_rst_valid", {31'd0, VALID}, 32'd0);
    idle_cycles(2);
    RST = 1'b1;
    idle_cycles(1);
    for (int i = 5; i < 8; i++) drive_bit(fb[i]);
    drive_bit(1'b1);
    idle_cycles(4);
    check("t5_valid_cnt", n_valid - v0, 0);
    check("t5_data_kept", {24'd0, DATA_OUT}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_cycles(4);
    check("t5_data_next", {24'd0, DATA_OUT}, 32'h3C);

    // Latency from first capture of the start bit
    v0 = n_valid;
    k0 = cyc + 1;
    send_frame(8'h00, 1'b1, 1'b1);
    idle_cycles(4);
    check("t6_valid_cnt", n_valid - v0, 1);
    check("t6_latency", last_valid_cyc - k0, 49);
    check("t6_data", {24'd0, DATA_OUT}, 32'h00);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
